meteor_spawn_rng: RTL and testbench

Parametrised pseudo-random spawn-parameter source for the meteorite game, replacing the free-running counter generator. A 32-bit Galois LFSR advances every clock. A round-robin request/valid front end serves N_CH meteor-slot requesters. Each draw yields position, x/y speed and direction sign, and draws that violate screen or speed constraints are re-drawn on following cycles.

---
 rtl/meteor_rng_pkg.sv | 28 ++
 rtl/meteor_spawn_rng_lfsr.sv | 32 +++
 rtl/meteor_spawn_rng.sv | 171 +++++++++++++++++
 tb/tb_meteor_spawn_rng.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/meteor_rng_pkg.sv
// ----------------------------------------------------------------------------
// meteor_rng_pkg
// Shared definitions for the meteor spawn random source: LFSR polynomial,
// reset/zero-substitution seed, FSM state type and the LFSR step function.
// ----------------------------------------------------------------------------
package meteor_rng_pkg;

  // Galois right-shift taps for x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] LFSR_TAPS    = 32'h8020_0003;
  // Value after reset, and the substitute when a zero seed is loaded
  localparam logic [31:0] LFSR_DEFAULT = 32'hACE1_2468;

  typedef enum logic {
    IDLE = 1'b0,
    DRAW = 1'b1
  } state_t;

  // One Galois step. Bit 31 of the taps is set, so a nonzero state can never
  // step to zero: either the shift keeps a set bit or bit 31 becomes 1.
  function automatic logic [31:0] lfsr_step(input logic [31:0] cur);
    if (cur[0]) begin
      return (cur >> 1) ^ LFSR_TAPS;
    end else begin
      return cur >> 1;
    end
  endfunction

endpackage

// File: rtl/meteor_spawn_rng_lfsr.sv
// ----------------------------------------------------------------------------
// galois_lfsr32
// Free-running 32-bit Galois LFSR with a synchronous seed load.
// Ports:
//   Clk      - clock
//   Reset    - synchronous, active-high; state returns to LFSR_DEFAULT
//   load     - load load_val at the next edge (priority over the advance)
//   load_val - seed; zero is replaced by LFSR_DEFAULT to keep the state nonzero
//   state    - current LFSR state
// ----------------------------------------------------------------------------
module galois_lfsr32
  import meteor_rng_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        load,
  input  logic [31:0] load_val,
  output logic [31:0] state
);

  // LFSR register: reset, seed load, otherwise advance every cycle
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= LFSR_DEFAULT;
    end else if (load) begin
      state <= (load_val == 32'd0) ? LFSR_DEFAULT : load_val;
    end else begin
      state <= lfsr_step(state);
    end
  end

endmodule

// File: rtl/meteor_spawn_rng.sv
// ----------------------------------------------------------------------------
// meteor_spawn_rng
// Pseudo-random spawn-parameter source for the meteor slots. A round-robin
// arbiter picks one requesting slot, the FSM draws fields from the LFSR until
// they satisfy the screen/speed rules (or clamps them on the last try) and
// returns them with a one-cycle one-hot valid pulse.
// Ports:
//   Clk, Reset          - clock, synchronous active-high reset
//   seed_load, seed     - reseed the LFSR (seed 0 selects LFSR_DEFAULT)
//   req[N_CH]           - level requests, held until the slot's valid bit
//   valid[N_CH]         - one-hot pulse marking the served slot
//   ch_id               - index of the served slot
//   new_pos             - spawn position, <= POS_MAX while valid
//   x_speed, y_speed    - nonzero speeds while valid
//   sign                - horizontal direction
// ----------------------------------------------------------------------------
module meteor_spawn_rng
  import meteor_rng_pkg::*;
#(
  parameter int POS_W     = 10,
  parameter int SPD_W     = 3,
  parameter int N_CH      = 4,
  parameter int POS_MAX   = 639,
  parameter int MAX_TRIES = 4,
  localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             seed_load,
  input  logic [31:0]      seed,
  input  logic [N_CH-1:0]  req,
  output logic [N_CH-1:0]  valid,
  output logic [CH_W-1:0]  ch_id,
  output logic [POS_W-1:0] new_pos,
  output logic [SPD_W-1:0] x_speed,
  output logic [SPD_W-1:0] y_speed,
  output logic             sign
);

  localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [POS_W-1:0] POS_MAX_V = POS_W'(POS_MAX);
  localparam logic [CH_W:0]    N_CH_V    = (CH_W + 1)'(N_CH);
  localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(N_CH - 1);
  localparam logic [TRY_W-1:0] LAST_TRY  = TRY_W'(MAX_TRIES - 1);

  if (POS_W + 2 * SPD_W > 31) begin : g_chk_width
    $error("meteor_spawn_rng: POS_W + 2*SPD_W must not exceed 31");
  end
  if (N_CH < 1 || N_CH > 16) begin : g_chk_nch
    $error("meteor_spawn_rng: N_CH must be within 1..16");
  end
  if (MAX_TRIES < 1) begin : g_chk_tries
    $error("meteor_spawn_rng: MAX_TRIES must be at least 1");
  end

  state_t           state;
  logic [CH_W-1:0]  rr_ptr;
  logic [CH_W-1:0]  slot;
  logic [TRY_W-1:0] tries;
  logic [31:0]      lfsr;

  galois_lfsr32 u_lfsr (
    .Clk      (Clk),
    .Reset    (Reset),
    .load     (seed_load),
    .load_val (seed),
    .state    (lfsr)
  );

  // Candidate fields straight from the current LFSR state
  logic [POS_W-1:0] cand_pos;
  logic [SPD_W-1:0] cand_x;
  logic [SPD_W-1:0] cand_y;
  logic             pos_ok;
  logic             accept;
  logic             last_try;
  logic [POS_W-1:0] fix_pos;
  logic [SPD_W-1:0] fix_x;
  logic [SPD_W-1:0] fix_y;

  assign cand_pos = lfsr[POS_W-1:0];
  assign cand_x   = lfsr[POS_W+SPD_W-1 -: SPD_W];
  assign cand_y   = lfsr[POS_W+2*SPD_W-1 -: SPD_W];
  assign pos_ok   = (cand_pos <= POS_MAX_V);
  assign accept   = pos_ok && (cand_x != '0) && (cand_y != '0);
  assign last_try = (tries == LAST_TRY);

  // The clamped values equal the candidates whenever the draw is accepted,
  // so they can be registered unconditionally when a result is issued.
  assign fix_pos = pos_ok ? cand_pos : POS_MAX_V;
  assign fix_x   = (cand_x == '0) ? SPD_W'(1) : cand_x;
  assign fix_y   = (cand_y == '0) ? SPD_W'(1) : cand_y;

  // The slot whose valid is high right now is excluded so that one slot
  // cannot be granted again before its requester has seen the pulse.
  logic [N_CH-1:0] req_m;
  logic            grant_any;
  logic [CH_W-1:0] grant_idx;
  logic [CH_W:0]   scan;

  assign req_m = req & ~valid;

  // Round-robin search: first masked request at or after rr_ptr, wrapping
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    scan      = '0;
    for (int i = 0; i < N_CH; i++) begin
      scan = {1'b0, rr_ptr} + (CH_W + 1)'(i);
      if (scan >= N_CH_V) begin
        scan = scan - N_CH_V;
      end else begin
        scan = scan;
      end
      if (!grant_any && req_m[scan[CH_W-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = scan[CH_W-1:0];
      end else begin
        grant_any = grant_any;
      end
    end
  end

  // Arbitration/draw FSM with registered result fields and valid pulse
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      slot    <= '0;
      tries   <= '0;
      valid   <= '0;
      ch_id   <= '0;
      new_pos <= '0;
      x_speed <= '0;
      y_speed <= '0;
      sign    <= 1'b0;
    end else begin
      valid <= '0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            slot  <= grant_idx;
            tries <= '0;
            state <= DRAW;
          end else begin
            state <= IDLE;
          end
        end
        DRAW: begin
          if (accept || last_try) begin
            new_pos     <= fix_pos;
            x_speed     <= fix_x;
            y_speed     <= fix_y;
            sign        <= lfsr[31];
            valid[slot] <= 1'b1;
            ch_id       <= slot;
            rr_ptr      <= (slot == LAST_CH) ? '0 : slot + CH_W'(1);
            state       <= IDLE;
          end else begin
            tries <= tries + TRY_W'(1);
            state <= DRAW;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_meteor_spawn_rng.sv
// ----------------------------------------------------------------------------
// tb_meteor_spawn_rng
// Scoreboard bench for meteor_spawn_rng: expected grants are queued when a
// request is driven and compared when the valid pulse appears. A second
// instance with MAX_TRIES=1 exercises the clamp path.
// ----------------------------------------------------------------------------
module tb_meteor_spawn_rng;
  import meteor_rng_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        seed_load, seed_load1;
  logic [31:0] seed, seed1;
  logic [3:0]  req, req1;
  logic [3:0]  valid, valid1;
  logic [1:0]  ch_id, ch_id1;
  logic [9:0]  new_pos, new_pos1;
  logic [2:0]  x_speed, x_speed1, y_speed, y_speed1;
  logic        sign, sign1;

  int n_tests = 0;
  int n_fail  = 0;
  int ncyc    = 0;

  typedef struct {
    int         slot;
    bit         full;
    logic [9:0] pos;
    logic [2:0] x;
    logic [2:0] y;
    logic       sgn;
    int         cyc;
  } exp_t;

  exp_t sb[$];

  always #5 Clk = ~Clk;

  meteor_spawn_rng dut (
    .Clk(Clk), .Reset(Reset), .seed_load(seed_load), .seed(seed), .req(req),
    .valid(valid), .ch_id(ch_id), .new_pos(new_pos), .x_speed(x_speed),
    .y_speed(y_speed), .sign(sign)
  );

  meteor_spawn_rng #(.MAX_TRIES(1)) dut1 (
    .Clk(Clk), .Reset(Reset), .seed_load(seed_load1), .seed(seed1), .req(req1),
    .valid(valid1), .ch_id(ch_id1), .new_pos(new_pos1), .x_speed(x_speed1),
    .y_speed(y_speed1), .sign(sign1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_next(input logic [31:0] l);
    return l[0] ? ((l >> 1) ^ 32'h8020_0003) : (l >> 1);
  endfunction

  // Reference draw sequence starting from LFSR value s; cyc = cycle of valid
  function automatic exp_t ref_draw(input logic [31:0] s, input int mt);
    exp_t e;
    logic [31:0] l;
    logic [9:0] p;
    logic [2:0] x, y;
    l = (s == 32'd0) ? 32'hACE1_2468 : s;
    e.slot = 0; e.full = 1'b1; e.cyc = 0;
    e.pos = '0; e.x = '0; e.y = '0; e.sgn = 1'b0;
    for (int t = 0; t < mt; t++) begin
      p = l[9:0]; x = l[12:10]; y = l[15:13];
      if ((p <= 10'd639 && x != 3'd0 && y != 3'd0) || t == mt - 1) begin
        e.pos = (p > 10'd639) ? 10'd639 : p;
        e.x   = (x == 3'd0) ? 3'd1 : x;
        e.y   = (y == 3'd0) ? 3'd1 : y;
        e.sgn = l[31];
        e.cyc = t + 2;
        return e;
      end
      l = ref_next(l);
    end
    return e;
  endfunction

  // Output monitor: pops the scoreboard on each valid pulse
  always @(negedge Clk) begin
    exp_t e;
    ncyc++;
    if (valid !== 4'd0) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 32'(valid), 32'd0);
      end else begin
        e = sb.pop_front();
        check("valid_onehot", 32'(valid), 32'd1 << e.slot);
        check("ch_id", 32'(ch_id), 32'(e.slot));
        check("pos_le_max", 32'(new_pos <= 10'd639), 32'd1);
        check("x_nonzero", 32'(x_speed != 3'd0), 32'd1);
        check("y_nonzero", 32'(y_speed != 3'd0), 32'd1);
        if (e.full) begin
          check("pos", 32'(new_pos), 32'(e.pos));
          check("x_speed", 32'(x_speed), 32'(e.x));
          check("y_speed", 32'(y_speed), 32'(e.y));
          check("sign", 32'(sign), 32'(e.sgn));
          check("latency_cycle", ncyc, e.cyc);
        end
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0) break;
      @(negedge Clk); #1;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  // Seeded request on one slot; fields fully predictable from the seed
  task automatic seeded_request(input int s, input logic [31:0] sv);
    exp_t e;
    @(posedge Clk); #1;
    req[s] = 1'b1; seed_load = 1'b1; seed = sv;
    e = ref_draw(sv, 4);
    e.slot = s;
    e.cyc  = ncyc + 1 + e.cyc;
    sb.push_back(e);
    @(posedge Clk); #1;
    seed_load = 1'b0;
    drain();
    req[s] = 1'b0;
  endtask

  initial begin
    exp_t e;
    int zeros;
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int zeros;
    Reset = 1'b1; req = '0; req1 = '0;
    seed_load = 1'b0; seed_load1 = 1'b0; seed = '0; seed1 = '0;
    repeat (3) @(posedge Clk);
    #1;
    Reset = 1'b0;
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_ch_id", 32'(ch_id), 32'd0);
    check("rst_pos", 32'(new_pos), 32'd0);
    check("rst_x", 32'(x_speed), 32'd0);
    check("rst_y", 32'(y_speed), 32'd0);
    check("rst_sign", 32'(sign), 32'd0);
    check("rst_state", 32'(dut.state), 32'(IDLE));
    check("rst_lfsr", dut.u_lfsr.state, 32'hACE1_2468);

    // Fairness: all slots requesting, expect 0,1,2,3,0
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      e.slot = k % 4; e.full = 1'b0; e.pos = '0; e.x = '0; e.y = '0;
      e.sgn = 1'b0; e.cyc = 0;
      sb.push_back(e);
    end
    drain();
    req = 4'b0000;

    // Deterministic, second seed on another slot, then a re-draw seed
    seeded_request(0, 32'h8000_2D2C);
    seeded_request(2, 32'h1234_5678);
    seeded_request(1, 32'h0000_A7FF);
    seeded_request(3, 32'hFFFF_FFFF);

    // Reset in cycle 1 of a request: nothing issued, everything cleared
    @(posedge Clk); #1;
    req = 4'b0100;
    @(posedge Clk); #1;
    Reset = 1'b1; req = 4'b0000;
    @(posedge Clk); #1;
    Reset = 1'b0;
    check("mid_rst_valid", 32'(valid), 32'd0);
    check("mid_rst_ch_id", 32'(ch_id), 32'd0);
    check("mid_rst_pos", 32'(new_pos), 32'd0);
    check("mid_rst_x", 32'(x_speed), 32'd0);
    check("mid_rst_y", 32'(y_speed), 32'd0);
    check("mid_rst_sign", 32'(sign), 32'd0);
    check("mid_rst_state", 32'(dut.state), 32'(IDLE));

    // Clamp with a single try: pos 1023, x 0, y 5
    @(posedge Clk); #1;
    req1 = 4'b0001; seed_load1 = 1'b1; seed1 = 32'h0000_A3FF;
    e = ref_draw(32'h0000_A3FF, 1);
    @(posedge Clk); #1;
    seed_load1 = 1'b0;
    @(posedge Clk); #1;
    check("fb_valid", 32'(valid1), 32'd1);
    check("fb_ch_id", 32'(ch_id1), 32'd0);
    check("fb_pos", 32'(new_pos1), 32'(e.pos));
    check("fb_x", 32'(x_speed1), 32'(e.x));
    check("fb_y", 32'(y_speed1), 32'(e.y));
    check("fb_sign", 32'(sign1), 32'(e.sgn));
    req1 = 4'b0000;

    // Zero seed substitution and long nonzero run
    @(posedge Clk); #1;
    seed_load = 1'b1; seed = 32'd0;
    @(posedge Clk); #1;
    seed_load = 1'b0;
    check("zero_seed", dut.u_lfsr.state, 32'hACE1_2468);
    @(posedge Clk); #1;
    check("lfsr_step", dut.u_lfsr.state, ref_next(32'hACE1_2468));
    zeros = 0;
    for (int i = 0; i < 20000; i++) begin
      @(posedge Clk); #1;
      if (dut.u_lfsr.state == 32'd0) zeros++;
    end
    check("lfsr_nonzero", 32'(zeros), 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
